// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline control definitions: stall encodings, exception codes, FSM states.
package pipe_ctrl_pkg;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [31:0] ZeroWord       = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;
    localparam logic [31:0] ERET_CODE      = 32'h0000_000e;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    // Deepest requesting stage wins; it freezes itself and everything upstream.
    function automatic logic [5:0] arbitrate(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        logic [5:0] s;
        s = STALL_NONE;
        priority case (1'b1)
            req_mem: s = STALL_MEM;
            req_ex:  s = STALL_EX;
            req_id:  s = STALL_ID;
            req_if:  s = STALL_IF;
            default: s = STALL_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pipe_ctrl_watchdog.sv
// Stall watchdog: EX-stall run counter with sticky timeout flag, plus a
// free-running count of cycles in which the PC was stalled.
module stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 1023,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       stall,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int RW = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT + 1) : 1;
    localparam logic [RW-1:0] RUN_MAX = RW'(STALL_TIMEOUT);

    logic [RW-1:0] run;

    always_ff @(posedge clk) begin
        if (rst) begin
            run           <= '0;
            stall_timeout <= 1'b0;
            stall_cycles  <= '0;
        end else begin
            if (stall[3] == Stop) begin
                if (run != RUN_MAX) run <= run + RW'(1);
                // flag rises on the edge where the run reaches the limit
                if (run >= RUN_MAX - RW'(1)) stall_timeout <= 1'b1;
            end else begin
                run <= '0;
            end
            if (stall[0] == Stop) stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall arbitration, exception flush and
// PC redirect with a short holdoff, plus the stall watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEF,
    parameter int          HOLDOFF       = 1,
    parameter int          STALL_TIMEOUT = 1023,
    parameter int          CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      cp0_epc_i,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    state_t        state, state_nx;
    logic [HW-1:0] hcnt, hcnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hcnt  <= '0;
        end else begin
            state <= state_nx;
            hcnt  <= hcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        hcnt_nx  = hcnt;
        flush    = 1'b0;
        new_pc   = ZeroWord;
        stall    = arbitrate(stallreq_if, stallreq_id,
                             stallreq_ex, stallreq_mem);
        if (rst) begin
            stall = STALL_NONE;
        end else begin
            unique case (state)
                IDLE: begin
                    // flush overrides any stall; requests are not remembered
                    if (excepttype_i != ZeroWord) begin
                        flush    = 1'b1;
                        stall    = STALL_NONE;
                        new_pc   = (excepttype_i == ERET_CODE) ? cp0_epc_i
                                                               : EXC_VECTOR;
                        state_nx = HOLD;
                        hcnt_nx  = HW'(HOLDOFF - 1);
                    end
                end
                HOLD: begin
                    if (hcnt == '0) state_nx = IDLE;
                    else            hcnt_nx  = hcnt - HW'(1);
                end
            endcase
        end
    end

    stall_watchdog #(
        .STALL_TIMEOUT(STALL_TIMEOUT),
        .CNT_W        (CNT_W)
    ) u_watchdog (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .stall_timeout(stall_timeout),
        .stall_cycles (stall_cycles)
    );

endmodule
